// File: rtl/audio_dac_sched_if.sv
// Bus between the audio source mixer and the sigma-delta DAC scheduler.
// The master drives the sources and the sample strobe; the slave returns the DAC word and status pulses.
interface audio_dac_sched_if;
  logic       CE_SAMPLE;
  logic [7:0] SRC0;
  logic [7:0] SRC1;
  logic [7:0] SRC2;
  logic [7:0] SRC3;
  logic [7:0] VOL;
  logic       MUTE;
  logic [7:0] DAC_DATA;
  logic       DAC_STB;
  logic       BUSY;
  logic       CLIP;
  logic       OVERRUN;

  modport master (
    output CE_SAMPLE, SRC0, SRC1, SRC2, SRC3, VOL, MUTE,
    input  DAC_DATA, DAC_STB, BUSY, CLIP, OVERRUN
  );

  modport slave (
    input  CE_SAMPLE, SRC0, SRC1, SRC2, SRC3, VOL, MUTE,
    output DAC_DATA, DAC_STB, BUSY, CLIP, OVERRUN
  );
endinterface

// File: rtl/audio_dac_sched.sv
// Sample-paced scheduler: mixes four excess-128 sources through one shared adder into an 8-bit DAC word.
// Optional feature: define DAC_SCHED_RAMP_EN to slew-limit DAC_DATA by RAMP_STEP per sample.
module audio_dac_sched #(
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  audio_dac_sched_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, ACC2, ACC3, SAT, OUT} state_t;

  state_t             state_q, state_d;
  logic [3:0][7:0]    src_q, src_d;
  logic [7:0]         vol_q, vol_d;
  logic               mute_q, mute_d;
  logic signed [10:0] acc_q, acc_d;
  logic [7:0]         sat_q, sat_d;
  logic [7:0]         dac_q, dac_d;
  logic               stb_q, stb_d;
  logic               busy_q, busy_d;
  logic               clip_q, clip_d;
  logic               ovr_q, ovr_d;

  logic [1:0]         src_idx;
  logic [1:0]         cur_vol;
  logic [7:0]         cur_src;
  logic signed [10:0] term_full;
  logic signed [10:0] term;
  logic [7:0]         target;
  logic [7:0]         out_next;

  // Inverting the MSB turns excess-128 into two's complement; the rest is sign extension.
  always_comb begin : term_sel
    case (state_q)
      ACC1:    src_idx = 2'd1;
      ACC2:    src_idx = 2'd2;
      ACC3:    src_idx = 2'd3;
      default: src_idx = 2'd0;
    endcase
    cur_src   = src_q[src_idx];
    cur_vol   = vol_q[{src_idx, 1'b0} +: 2];
    term_full = {{4{~cur_src[7]}}, cur_src[6:0]};
    case (cur_vol)
      2'd0:    term = '0;
      2'd1:    term = term_full >>> 2;
      2'd2:    term = term_full >>> 1;
      default: term = term_full;
    endcase
  end

  assign target = mute_q ? 8'h80 : sat_q;

`ifdef DAC_SCHED_RAMP_EN
  localparam logic [8:0] STEP_W = 9'(RAMP_STEP);
  localparam logic [7:0] STEP_N = 8'(RAMP_STEP);

  logic [8:0] tgt_w;
  logic [8:0] dac_w;

  // Compared in 9 bits so a full-scale jump can never wrap past the target.
  always_comb begin : ramp
    tgt_w = {1'b0, target};
    dac_w = {1'b0, dac_q};
    if (tgt_w > dac_w) begin
      out_next = (tgt_w - dac_w <= STEP_W) ? target : dac_q + STEP_N;
    end else begin
      out_next = (dac_w - tgt_w <= STEP_W) ? target : dac_q - STEP_N;
    end
  end
`else
  assign out_next = target;
`endif

  always_comb begin : next_state
    state_d = state_q;
    src_d   = src_q;
    vol_d   = vol_q;
    mute_d  = mute_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    dac_d   = dac_q;
    stb_d   = 1'b0;
    clip_d  = 1'b0;
    ovr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.CE_SAMPLE) begin
          src_d   = {bus.SRC3, bus.SRC2, bus.SRC1, bus.SRC0};
          vol_d   = bus.VOL;
          mute_d  = bus.MUTE;
          acc_d   = '0;
          state_d = ACC0;
        end
      end
      ACC0: begin
        acc_d   = acc_q + term;
        state_d = ACC1;
      end
      ACC1: begin
        acc_d   = acc_q + term;
        state_d = ACC2;
      end
      ACC2: begin
        acc_d   = acc_q + term;
        state_d = ACC3;
      end
      ACC3: begin
        acc_d   = acc_q + term;
        state_d = SAT;
      end
      SAT: begin
        if (acc_q > 11'sd127) begin
          sat_d  = 8'hFF;
          clip_d = 1'b1;
        end else if (acc_q < -11'sd128) begin
          sat_d  = 8'h00;
          clip_d = 1'b1;
        end else begin
          sat_d  = acc_q[7:0] ^ 8'h80;
        end
        state_d = OUT;
      end
      OUT: begin
        dac_d   = out_next;
        stb_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A strobe arriving mid-sample is dropped; the running sample carries on.
    if (bus.CE_SAMPLE && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin : regs
    if (RESET) begin
      state_q <= IDLE;
      src_q   <= '0;
      vol_q   <= '0;
      mute_q  <= 1'b0;
      acc_q   <= '0;
      sat_q   <= 8'h80;
      dac_q   <= 8'h80;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      vol_q   <= vol_d;
      mute_q  <= mute_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      dac_q   <= dac_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      clip_q  <= clip_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.DAC_DATA = dac_q;
  assign bus.DAC_STB  = stb_q;
  assign bus.BUSY     = busy_q;
  assign bus.CLIP     = clip_q;
  assign bus.OVERRUN  = ovr_q;

endmodule
